// File: rtl/scan_test_sequencer.sv
`default_nettype none
// ==========================================================================
// scan_test_sequencer : per-vector scan load / capture / unload and compare
// Rev 1.0
// ==========================================================================
module scan_test_sequencer #(
   parameter int PI_W     = 8,
   parameter int SCAN_LEN = 26,
   parameter int SETTLE   = 2,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vec_valid,
   output logic                vec_ready,
   input  logic [PI_W-1:0]     vec_pi,
   input  logic [SCAN_LEN-1:0] vec_ppi,
   input  logic [PI_W-1:0]     exp_po,
   input  logic [SCAN_LEN-1:0] exp_ppo,
   output logic [PI_W-1:0]     core_pi,
   input  logic [PI_W-1:0]     core_po,
   output logic                scan_en,
   output logic                scan_in,
   input  logic                scan_out,
   output logic                core_ce,
   output logic                result_valid,
   output logic                result_pass,
   output logic [CNT_W-1:0]    vec_count,
   output logic [CNT_W-1:0]    fail_count
);
   localparam int c_MAXC = (SCAN_LEN > SETTLE) ? SCAN_LEN : SETTLE;
   localparam int c_BC_W = $clog2(c_MAXC + 1);
   localparam logic [c_BC_W-1:0] c_SCAN_LAST   = c_BC_W'(SCAN_LEN - 1);
   localparam logic [c_BC_W-1:0] c_SETTLE_LAST = c_BC_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]  c_CNT_MAX     = '1;

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_LOAD    = 3'd1;
   localparam logic [2:0] c_APPLY   = 3'd2;
   localparam logic [2:0] c_CAPTURE = 3'd3;
   localparam logic [2:0] c_UNLOAD  = 3'd4;
   localparam logic [2:0] c_REPORT  = 3'd5;

   logic [2:0]          r_state;
   logic [2:0]          w_next_state;
   logic [c_BC_W-1:0]   r_bcnt;
   logic [PI_W-1:0]     r_pi;
   logic [PI_W-1:0]     r_exp_po;
   logic [SCAN_LEN-1:0] r_ppi;
   logic [SCAN_LEN-1:0] r_ppo;
   logic                r_flag;
   logic [CNT_W-1:0]    r_vec_cnt;
   logic [CNT_W-1:0]    r_fail_cnt;
   logic                w_accept;

   assign w_accept   = (r_state == c_IDLE) && vec_valid;
   assign vec_count  = r_vec_cnt;
   assign fail_count = r_fail_cnt;

   always_ff @(posedge clk) begin
      if (reset) r_state <= c_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:    if (w_accept) w_next_state = c_LOAD;
         c_LOAD:    if (r_bcnt == c_SCAN_LAST) w_next_state = c_APPLY;
         c_APPLY:   if (r_bcnt == c_SETTLE_LAST) w_next_state = c_CAPTURE;
         c_CAPTURE: w_next_state = c_UNLOAD;
         c_UNLOAD:  if (r_bcnt == c_SCAN_LAST) w_next_state = c_REPORT;
         c_REPORT:  w_next_state = c_IDLE;
         default:   w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      vec_ready    = 1'b0;
      core_pi      = '0;
      scan_en      = 1'b0;
      scan_in      = 1'b0;
      core_ce      = 1'b0;
      result_valid = 1'b0;
      result_pass  = 1'b0;
      case (r_state)
         c_IDLE:    vec_ready = 1'b1;
         c_LOAD: begin
            scan_en = 1'b1;
            core_ce = 1'b1;
            scan_in = r_ppi[SCAN_LEN-1];
         end
         c_APPLY:   core_pi = r_pi;
         c_CAPTURE: begin
            core_pi = r_pi;
            core_ce = 1'b1;
         end
         c_UNLOAD: begin
            core_pi = r_pi;
            scan_en = 1'b1;
            core_ce = 1'b1;
         end
         c_REPORT: begin
            core_pi      = r_pi;
            result_valid = 1'b1;
            result_pass  = ~r_flag;
         end
         default: ;
      endcase
   end

   // Scan-in and expected-PPO registers shift left so the MSB is always the current bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bcnt     <= '0;
         r_pi       <= '0;
         r_exp_po   <= '0;
         r_ppi      <= '0;
         r_ppo      <= '0;
         r_flag     <= 1'b0;
         r_vec_cnt  <= '0;
         r_fail_cnt <= '0;
      end else begin
         if (w_next_state != r_state)
            r_bcnt <= '0;
         else if (r_state == c_LOAD || r_state == c_APPLY || r_state == c_UNLOAD)
            r_bcnt <= r_bcnt + 1'b1;

         case (r_state)
            c_IDLE: if (w_accept) begin
               r_pi     <= vec_pi;
               r_ppi    <= vec_ppi;
               r_exp_po <= exp_po;
               r_ppo    <= exp_ppo;
               r_flag   <= 1'b0;
            end
            c_LOAD:    r_ppi <= r_ppi << 1;
            c_CAPTURE: if (core_po != r_exp_po) r_flag <= 1'b1;
            c_UNLOAD: begin
               if (scan_out != r_ppo[SCAN_LEN-1]) r_flag <= 1'b1;
               r_ppo <= r_ppo << 1;
            end
            c_REPORT: begin
               if (r_vec_cnt != c_CNT_MAX) r_vec_cnt <= r_vec_cnt + 1'b1;
               if (r_flag && (r_fail_cnt != c_CNT_MAX)) r_fail_cnt <= r_fail_cnt + 1'b1;
               r_flag <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_scan_test_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_scan_test_sequencer : directed bench with a scan-chain core model
// Rev 1.0
// ==========================================================================
module tb_scan_test_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vec_valid = 1'b0;
   logic [7:0]  vec_pi = '0, exp_po = '0;
   logic [25:0] vec_ppi = '0, exp_ppo = '0;
   logic        vec_ready, scan_en, scan_in, scan_out, core_ce, result_valid, result_pass;
   logic [7:0]  core_pi, core_po;
   logic [15:0] vec_count, fail_count;
   logic        d2_ready, d2_scan_en, d2_scan_in, d2_core_ce, d2_rv, d2_rp;
   logic [7:0]  d2_core_pi;
   logic [3:0]  d2_vec_count, d2_fail_count;

   int n_chk = 0, n_pass = 0, cyc = 0, res_cnt = 0;

   scan_test_sequencer u_dut (
      .clk(clk), .reset(reset), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .vec_pi(vec_pi), .vec_ppi(vec_ppi), .exp_po(exp_po), .exp_ppo(exp_ppo),
      .core_pi(core_pi), .core_po(core_po), .scan_en(scan_en), .scan_in(scan_in),
      .scan_out(scan_out), .core_ce(core_ce), .result_valid(result_valid),
      .result_pass(result_pass), .vec_count(vec_count), .fail_count(fail_count));

   // Narrow-count copy runs in lockstep with the main instance and shares its core model.
   scan_test_sequencer #(.CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .vec_valid(vec_valid), .vec_ready(d2_ready),
      .vec_pi(vec_pi), .vec_ppi(vec_ppi), .exp_po(exp_po), .exp_ppo(exp_ppo),
      .core_pi(d2_core_pi), .core_po(core_po), .scan_en(d2_scan_en), .scan_in(d2_scan_in),
      .scan_out(scan_out), .core_ce(d2_core_ce), .result_valid(d2_rv),
      .result_pass(d2_rp), .vec_count(d2_vec_count), .fail_count(d2_fail_count));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (result_valid) res_cnt++;

   // Toy core: capture rotates the chain and XORs in the PIs; PO = low chain byte + PI.
   logic [25:0] chain = '0;
   int          uidx = 0, flip_at = 0;
   logic        flip_en = 1'b0;
   logic [7:0]  po_xor = '0;

   function automatic logic [25:0] f_ppo(input logic [25:0] c, input logic [7:0] p);
      return {c[24:0], c[25]} ^ {18'h0, p};
   endfunction
   function automatic logic [7:0] f_po(input logic [25:0] c, input logic [7:0] p);
      return c[7:0] + p;
   endfunction

   always @(posedge clk) begin
      if (core_ce) begin
         if (scan_en) begin
            chain <= {chain[24:0], scan_in};
            uidx  <= uidx + 1;
         end else begin
            chain <= f_ppo(chain, core_pi);
            uidx  <= 0;
         end
      end
   end
   assign scan_out = chain[25] ^ (flip_en && (uidx == flip_at));
   assign core_po  = f_po(chain, core_pi) ^ po_xor;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic do_vec(input logic [7:0] pi, input logic [25:0] ppi, input logic [7:0] pox,
                         input int flip, input logic hold, input logic exp_pass, output int acc);
      int  waited;
      bit  got_cap;
      vec_pi = pi; vec_ppi = ppi;
      exp_po = f_po(ppi, pi); exp_ppo = f_ppo(ppi, pi);
      po_xor = pox; flip_en = (flip >= 0); flip_at = flip;
      vec_valid = 1'b1;
      waited = 0;
      while (!vec_ready && waited < 200) begin @(negedge clk); waited++; end
      acc = cyc;
      if (!vec_ready) begin
         chk("accept_timeout", 0, 1);
         vec_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (!hold) vec_valid = 1'b0;
      chk("busy_ready", 32'(vec_ready), 0);
      waited = 0; got_cap = 0;
      while (!result_valid && waited < 200) begin
         if (core_ce && !scan_en && !got_cap) begin
            got_cap = 1;
            chk("scan_load", 32'(chain), 32'(ppi));
            chk("capture_pi", 32'(core_pi), 32'(pi));
         end
         @(negedge clk); waited++;
      end
      if (!result_valid) chk("result_timeout", 0, 1);
      else begin
         chk("latency", 32'(cyc - acc), 56);
         chk("result_pass", 32'(result_pass), 32'(exp_pass));
      end
   endtask

   initial begin
      int a0, a1, a2, r0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_ready", 32'(vec_ready), 1);
      chk("rst_ce_en", 32'({core_ce, scan_en, scan_in, result_valid}), 0);
      chk("rst_counts", 32'({vec_count, fail_count}), 0);

      // Mid-UNLOAD reset after one completed vector
      do_vec(8'h11, 26'h0F0F0F0, 8'h00, -1, 1'b0, 1'b1, a0);
      @(negedge clk);
      chk("pre_rst_vec", 32'(vec_count), 1);
      vec_valid = 1'b1;
      @(negedge clk);
      vec_valid = 1'b0;
      repeat (35) @(negedge clk);
      chk("in_unload", 32'({scan_en, core_ce, core_pi}), 32'({2'b11, 8'h11}));
      r0 = res_cnt;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("abort_ready", 32'(vec_ready), 1);
      chk("abort_outs", 32'({core_pi, scan_en, scan_in, core_ce, result_valid, result_pass}), 0);
      chk("abort_counts", 32'({vec_count, fail_count}), 0);
      repeat (60) @(negedge clk);
      chk("abort_no_pulse", 32'(res_cnt - r0), 0);

      // Passing, PPO-fault and PO-fault vectors
      do_vec(8'hA5, 26'h2AAAAAA, 8'h00, -1, 1'b0, 1'b1, a0);
      @(negedge clk);
      chk("t2_counts", 32'({vec_count, fail_count}), 32'({16'd1, 16'd0}));
      chk("t2_idle_pi", 32'({vec_ready, core_pi}), 32'({1'b1, 8'h00}));
      do_vec(8'h3C, 26'h1234567, 8'h00, 5, 1'b0, 1'b0, a0);
      @(negedge clk);
      chk("t3_counts", 32'({vec_count, fail_count}), 32'({16'd2, 16'd1}));
      do_vec(8'h5A, 26'h3FFFFFF, 8'h01, -1, 1'b0, 1'b0, a0);
      @(negedge clk);
      chk("t4_counts", 32'({vec_count, fail_count}), 32'({16'd3, 16'd2}));

      // Back-to-back with vec_valid held high
      r0 = res_cnt;
      do_vec(8'h01, 26'h0000001, 8'h00, -1, 1'b1, 1'b1, a0);
      do_vec(8'hFE, 26'h2000000, 8'h00, -1, 1'b1, 1'b1, a1);
      do_vec(8'h77, 26'h15A5A5A, 8'h00, -1, 1'b0, 1'b1, a2);
      chk("b2b_space1", 32'(a1 - a0), 57);
      chk("b2b_space2", 32'(a2 - a1), 57);
      repeat (70) @(negedge clk);
      chk("b2b_pulses", 32'(res_cnt - r0), 3);
      chk("t5_counts", 32'({vec_count, fail_count}), 32'({16'd6, 16'd2}));
      chk("t5_counts4", 32'({d2_vec_count, d2_fail_count}), 32'({4'd6, 4'd2}));

      // Saturation of the 4-bit counters
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 17; i++)
         do_vec(8'(i), 26'(i * 97 + 5), 8'h80, -1, 1'b0, 1'b0, a0);
      @(negedge clk);
      chk("sat_counts4", 32'({d2_vec_count, d2_fail_count}), 32'h0000_00FF);
      chk("sat_counts16", 32'({vec_count, fail_count}), 32'({16'd17, 16'd17}));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
`default_nettype wire
